// File: rtl/instr_fsm.sv
// -----------------------------------------------------------------------------
// instr_fsm -- multi-cycle instruction controller for the Simple RISC Machine.
//
// Latches a 16-bit instruction into IR when idle and started, decodes it, and
// steps the datapath through one control state per clock. All outputs are
// Moore: they depend only on the current state and the held instruction.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low reset
//   s         in   1   start, sampled only while waiting
//   in        in  16   instruction word, latched into IR on accept
//   w         out  1   high only while waiting for a new instruction
//   readnum   out  3   register-file read index
//   writenum  out  3   register-file write index
//   write     out  1   register-file write enable
//   vsel      out  4   one-hot writeback select (1000 mdata, 0100 sximm8,
//                      0010 PC, 0001 C)
//   loada/b/c out  1   datapath A/B/C register load enables
//   loads     out  1   status register load enable
//   asel      out  1   forces the ALU A operand to zero
//   bsel      out  1   selects sximm5 as the B operand (never used yet)
//   shift     out  2   shifter control
//   ALUop     out  2   00 add, 01 sub, 10 and, 11 not-B
//   sximm8    out 16   sign-extended IR[7:0]
//   sximm5    out 16   sign-extended IR[4:0]
// -----------------------------------------------------------------------------
module instr_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  // Instruction field decode
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];

  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

  logic w_is_movi;
  logic w_is_movr;
  logic w_is_alu;
  logic w_is_cmp;

  assign w_is_movi = (w_opcode == OPC_MOV) && (w_op == OP_MOVI);
  assign w_is_movr = (w_opcode == OPC_MOV) && (w_op == OP_MOVR);
  assign w_is_alu  = (w_opcode == OPC_ALU);
  assign w_is_cmp  = w_is_alu && (w_op == OP_CMP);

  // State and instruction registers. Reset clears IR as well so the
  // immediates read zero immediately, even mid-instruction.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && s) begin
        r_ir <= in;
      end
    end
  end

  // Next-state and Moore outputs
  // NOTE: every output and the next state get a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;

    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end

      S_DECODE: begin
        if (w_is_movi) begin
          w_next = S_WRITE_IMM;
        end else if (w_is_movr || (w_is_alu && w_op == OP_MVN)) begin
          w_next = S_GET_B;   // single-operand forms skip the A fetch
        end else if (w_is_alu) begin
          w_next = S_GET_A;
        end else begin
          w_next = S_WAIT;    // undefined: retire silently
        end
      end

      S_WRITE_IMM: begin
        write    = 1'b1;
        writenum = w_rn;
        vsel     = VSEL_SXIMM8;
        w_next   = S_WAIT;
      end

      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end

      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_EXEC;
      end

      S_EXEC: begin
        shift = w_sh;
        // MOV reg passes B through as 0 + B
        ALUop = w_is_alu ? w_op : 2'b00;
        asel  = w_is_movr;
        if (w_is_cmp) begin
          loads  = 1'b1;     // compare only updates status, no writeback
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WRITE_REG;
        end
      end

      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = w_rd;
        vsel     = VSEL_C;
        w_next   = S_WAIT;
      end

      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_fsm.sv
// -----------------------------------------------------------------------------
// tb_instr_fsm -- self-checking bench for instr_fsm.
//
// The reference model turns each instruction into the list of control vectors
// expected on each busy cycle, derived from the instruction-class rules, and
// an independent busy-length table. Directed cases come first, then random
// instructions with random start/idle patterns and noise on s/in while busy.
// -----------------------------------------------------------------------------
module tb_instr_fsm;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  instr_fsm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (aluop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } ctl_t;

  ctl_t obs;
  assign obs = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, aluop, sximm8, sximm5};

  int          n_cmp  = 0;
  int          n_fail = 0;
  ctl_t        exp_q[$];
  logic [15:0] last_ir;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle vector: defaults plus the immediates of whatever IR holds
  function automatic ctl_t base_vec(input logic [15:0] ir);
    ctl_t v;
    int   i8;
    int   i5;
    v      = '0;
    v.vsel = 4'b0001;
    i8 = int'(ir[7:0]);
    if (i8 >= 128) i8 -= 256;
    i5 = int'(ir[4:0]);
    if (i5 >= 16) i5 -= 32;
    v.sximm8 = 16'(i8);
    v.sximm5 = 16'(i5);
    return v;
  endfunction

  function automatic ctl_t wait_vec(input logic [15:0] ir);
    ctl_t v;
    v   = base_vec(ir);
    v.w = 1'b1;
    return v;
  endfunction

  function automatic int busy_len(input logic [15:0] ir);
    case (ir[15:11])
      5'b11010: return 2;          // MOV imm
      5'b11000: return 4;          // MOV reg
      5'b10100: return 5;          // ADD
      5'b10101: return 4;          // CMP
      5'b10110: return 5;          // AND
      5'b10111: return 4;          // MVN
      default:  return 1;          // undefined
    endcase
  endfunction

  // Expected control vector for each busy cycle, DECODE first
  function automatic void build(input logic [15:0] ir);
    ctl_t       b;
    ctl_t       v;
    logic [2:0] opc;
    logic [1:0] op;
    bit         movi;
    bit         movr;
    bit         alu;
    bit         cmp;
    opc  = ir[15:13];
    op   = ir[12:11];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    alu  = (opc == 3'b101);
    cmp  = alu && (op == 2'b01);
    exp_q.delete();
    b = base_vec(ir);
    exp_q.push_back(b);
    if (movi) begin
      v = b; v.write = 1'b1; v.writenum = ir[10:8]; v.vsel = 4'b0100;
      exp_q.push_back(v);
    end else if (movr || alu) begin
      if (alu && op != 2'b11) begin
        v = b; v.loada = 1'b1; v.readnum = ir[10:8];
        exp_q.push_back(v);
      end
      v = b; v.loadb = 1'b1; v.readnum = ir[2:0];
      exp_q.push_back(v);
      v = b; v.shift = ir[4:3]; v.aluop = alu ? op : 2'b00; v.asel = movr;
      if (cmp) v.loads = 1'b1;
      else     v.loadc = 1'b1;
      exp_q.push_back(v);
      if (!cmp) begin
        v = b; v.write = 1'b1; v.writenum = ir[7:5]; v.vsel = 4'b0001;
        exp_q.push_back(v);
      end
    end
  endfunction

  // Issue one instruction from a WAIT cycle. s_mode: 0 drop s while busy,
  // 1 hold s high, 2 random s and in while busy. Returns in the first WAIT
  // cycle after the instruction, with s left as the mode left it.
  task automatic issue(input logic [15:0] instr, input int s_mode);
    int busy;
    check("ready_w", 64'(w), 64'(1'b1));
    build(instr);
    in = instr;
    s  = 1'b1;
    step();
    last_ir = instr;
    busy = 0;
    while (w !== 1'b1 && busy < 12) begin
      if (busy < exp_q.size()) check("busy_ctl", 64'(obs), 64'(exp_q[busy]));
      busy++;
      if (s_mode == 2) begin
        s  = 1'($urandom);
        in = 16'($urandom);
      end else begin
        s = (s_mode == 1);
      end
      step();
    end
    check("busy_cycles", 64'(busy), 64'(busy_len(instr)));
    check("wait_ctl", 64'(obs), 64'(wait_vec(last_ir)));
  endtask

  task automatic idle(input int cycles);
    s = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      check("idle_ctl", 64'(obs), 64'(wait_vec(last_ir)));
    end
  endtask

  logic [31:0] r;
  logic [15:0] ri;

  initial begin
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0000;
    last_ir = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", 64'(obs), 64'(wait_vec(16'h0000)));
    reset_n = 1'b1;
    idle(1);

    // MOV R0,#-5
    issue(16'hD0FB, 0);
    check("movi_sximm8", 64'(sximm8), 64'(16'hFFFB));
    idle(1);
    // ADD R2,R1,R0,LSL#1
    issue(16'hA148, 0);
    // CMP R1,R0
    issue(16'hA900, 2);
    s = 1'b0;
    // MVN R3,R0
    issue(16'hB860, 0);
    // Undefined with s held, then MOV R1,#7 on the very next WAIT cycle
    issue(16'h0000, 1);
    issue(16'hD107, 0);
    check("mov7_sximm8", 64'(sximm8), 64'(16'h0007));
    idle(2);

    // Reset during EXEC of ADD
    in = 16'hA148;
    s  = 1'b1;
    step();                 // DECODE
    s  = 1'b0;
    step();                 // GET_A
    step();                 // GET_B
    step();                 // EXEC
    check("pre_rst_loadc", 64'(loadc), 64'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_ctl", 64'(obs), 64'(wait_vec(16'h0000)));
    step();
    check("rst_held_ctl", 64'(obs), 64'(wait_vec(16'h0000)));
    reset_n = 1'b1;
    last_ir = 16'h0000;
    idle(2);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0:       ri = {5'b11010, r[10:0]};
        1:       ri = {5'b11000, r[10:0]};
        2:       ri = {5'b10100, r[10:0]};
        3:       ri = {5'b10101, r[10:0]};
        4:       ri = {5'b10110, r[10:0]};
        5:       ri = {5'b10111, r[10:0]};
        default: ri = r[15:0];
      endcase
      issue(ri, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      else s = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
